// File: rtl/demux16_pkg.sv
// Shared types and constants for the 1:16 demultiplexing frame collector.
package demux16_pkg;

  localparam int unsigned LANES = 16;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = 5;
  localparam logic [LANES-1:0] FULL_MASK = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_e;

  // Number of set bits in a lane mask (0..16).
  function automatic logic [CNT_W-1:0] popcount16(input logic [LANES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/demux16_frame_collector_lane_decoder.sv
// 4-to-16 one-hot lane decode, gated by the beat accept strobe.
module lane_decoder
  import demux16_pkg::*;
(
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [LANES-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int k = 0; k < LANES; k++) begin
      if (en_i && (sel_i == SEL_W'(k))) onehot_o[k] = 1'b1;
    end
  end

endmodule

// File: rtl/demux16_frame_collector.sv
// 1:16 bit-serial frame collector with valid/ready frame output.
// Optional idle timeout on partial frames is built when DEMUX_TIMEOUT_EN is defined.
module demux16_frame_collector
  import demux16_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TO_W           = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic [SEL_W-1:0] sel,
  input  logic             din_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [0:LANES-1] frame,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [CNT_W-1:0] fill_count,
  output logic             dup_err,
  output logic             timeout
);

  state_e           state_q, state_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic [0:LANES-1] frame_q, frame_d;
  logic [CNT_W-1:0] fill_q;
  logic             frame_valid_q;
  logic             dup_q, dup_d;
  logic             to_q, to_d;
  logic [LANES-1:0] wen;
  logic             accept;
  logic             to_hit;

  assign in_ready = (state_q != FULL);
  assign accept   = din_valid & in_ready & ~clear;

  lane_decoder u_lane_decoder (
    .sel_i    (sel),
    .en_i     (accept),
    .onehot_o (wen)
  );

`ifdef DEMUX_TIMEOUT_EN
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            fill_idle;

  // Counts consecutive FILL cycles without an accepted beat; zero everywhere else.
  assign fill_idle = (state_q == FILL) && !accept && !clear;
  assign to_hit    = fill_idle && (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (fill_idle && !to_hit) cnt_d = cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = TIMEOUT_CYCLES ^ TO_W;
  assign to_hit     = 1'b0;
`endif

  // Next state, mask and frame; clear outranks every other event.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    frame_d = frame_q;
    dup_d   = 1'b0;
    to_d    = 1'b0;
    if (clear) begin
      state_d = IDLE;
      mask_d  = '0;
      frame_d = '0;
    end else if (state_q == FULL) begin
      if (frame_ready) begin
        state_d = IDLE;
        mask_d  = '0;
        frame_d = '0;
      end
    end else if (accept) begin
      mask_d = mask_q | wen;
      dup_d  = |(mask_q & wen);
      for (int k = 0; k < LANES; k++) begin
        if (wen[k]) frame_d[k] = din;
      end
      state_d = (mask_d == FULL_MASK) ? FULL : FILL;
    end else if (to_hit) begin
      state_d = IDLE;
      mask_d  = '0;
      frame_d = '0;
      to_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mask_q        <= '0;
      frame_q       <= '0;
      fill_q        <= '0;
      frame_valid_q <= 1'b0;
      dup_q         <= 1'b0;
      to_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      frame_q       <= frame_d;
      fill_q        <= popcount16(mask_d);
      frame_valid_q <= (state_d == FULL);
      dup_q         <= dup_d;
      to_q          <= to_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign fill_count  = fill_q;
  assign dup_err     = dup_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_demux16_frame_collector.sv
// Self-checking bench: lane-array reference model compared every cycle, plus directed literal checks.
module tb_demux16_frame_collector;

`ifdef DEMUX_TIMEOUT_EN
  localparam int TO_LIM = 8;
`endif

  logic        clk, rst_n;
  logic        din, din_valid, clear, frame_ready;
  logic [3:0]  sel;
  logic        in_ready, frame_valid, dup_err, timeout;
  logic [0:15] frame;
  logic [4:0]  fill_count;

  int checks = 0;
  int errors = 0;
  int dup_seen = 0;
  int to_seen = 0;

`ifdef DEMUX_TIMEOUT_EN
  demux16_frame_collector #(.TIMEOUT_CYCLES(8), .TO_W(4)) dut (
`else
  demux16_frame_collector dut (
`endif
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .din_valid(din_valid),
    .in_ready(in_ready), .clear(clear), .frame(frame), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .fill_count(fill_count), .dup_err(dup_err), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which lanes hold data, their bits, and whether a frame is on offer.
  logic m_bit[16];
  logic m_has[16];
  logic m_full, m_dup, m_to;
  int   m_idle;

  function automatic int m_count();
    int n = 0;
    for (int k = 0; k < 16; k++) if (m_has[k]) n++;
    return n;
  endfunction

  function automatic logic [0:15] m_frame();
    logic [0:15] f;
    for (int k = 0; k < 16; k++) f[k] = m_bit[k];
    return f;
  endfunction

  task automatic m_drop();
    for (int k = 0; k < 16; k++) begin
      m_bit[k] = 1'b0;
      m_has[k] = 1'b0;
    end
    m_full = 1'b0;
    m_idle = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_drop();
      m_dup = 1'b0;
      m_to  = 1'b0;
    end else begin
      m_dup = 1'b0;
      m_to  = 1'b0;
      if (clear) m_drop();
      else if (m_full) begin
        if (frame_ready) m_drop();
      end else if (din_valid) begin
        if (m_has[sel]) m_dup = 1'b1;
        m_has[sel] = 1'b1;
        m_bit[sel] = din;
        m_idle = 0;
        if (m_count() == 16) m_full = 1'b1;
      end else if (m_count() > 0) begin
        m_idle++;
`ifdef DEMUX_TIMEOUT_EN
        if (m_idle == TO_LIM) begin
          m_drop();
          m_to = 1'b1;
        end
`endif
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    check("frame", 32'(frame), 32'(m_frame()));
    check("fill_count", 32'(fill_count), 32'(m_count()));
    check("frame_valid", 32'(frame_valid), 32'(m_full));
    check("in_ready", 32'(in_ready), 32'(!m_full));
    check("dup_err", 32'(dup_err), 32'(m_dup));
    check("timeout", 32'(timeout), 32'(m_to));
    if (dup_err) dup_seen++;
    if (timeout) to_seen++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] s, input logic d);
    sel = s; din = d; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  int d0;
  logic [3:0] s4;

  initial begin
    rst_n = 1'b0; din = 1'b0; sel = '0; din_valid = 1'b0; clear = 1'b0; frame_ready = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // 1: reset mid-FILL discards partial data
    for (int i = 0; i < 5; i++) begin
      s4 = 4'(i);
      beat(s4, 1'b1);
    end
    check("t1_fill_before_rst", 32'(fill_count), 32'd5);
    rst_n = 1'b0;
    #2;
    check("t1_frame", 32'(frame), 32'h0);
    check("t1_fill", 32'(fill_count), 32'd0);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    idle(1);
    rst_n = 1'b1;
    idle(1);

    // 2: full sweep, frame[k] = k[0]
    for (int i = 0; i < 16; i++) begin
      s4 = 4'(i);
      beat(s4, s4[0]);
    end
    check("t2_frame_valid", 32'(frame_valid), 32'd1);
    check("t2_frame", 32'(frame), 32'h5555);
    check("t2_in_ready", 32'(in_ready), 32'd0);
    check("t2_fill", 32'(fill_count), 32'd16);

    // 3: backpressure holds the frame; pending beats ignored
    sel = 4'd2; din = 1'b0; din_valid = 1'b1;
    idle(10);
    check("t3_frame_held", 32'(frame), 32'h5555);
    check("t3_valid_held", 32'(frame_valid), 32'd1);
    din_valid = 1'b0;
    frame_ready = 1'b1;
    idle(1);
    frame_ready = 1'b0;
    check("t3_valid_drop", 32'(frame_valid), 32'd0);
    check("t3_fill", 32'(fill_count), 32'd0);
    check("t3_in_ready", 32'(in_ready), 32'd1);

    // 4: duplicate lane overwrites and pulses dup_err once
    d0 = dup_seen;
    beat(4'd3, 1'b1);
    beat(4'd3, 1'b0);
    idle(2);
    check("t4_dup_pulses", 32'(dup_seen - d0), 32'd1);
    check("t4_frame3", 32'(frame[3]), 32'd0);
    check("t4_fill", 32'(fill_count), 32'd1);
    do_clear();

    // 5: clear beats the completing beat
    for (int i = 0; i < 15; i++) begin
      s4 = 4'(i);
      beat(s4, 1'b1);
    end
    check("t5_fill15", 32'(fill_count), 32'd15);
    d0 = dup_seen;
    sel = 4'd15; din = 1'b1; din_valid = 1'b1; clear = 1'b1;
    idle(1);
    din_valid = 1'b0; clear = 1'b0;
    idle(1);
    check("t5_fill", 32'(fill_count), 32'd0);
    check("t5_valid", 32'(frame_valid), 32'd0);
    check("t5_frame", 32'(frame), 32'h0);
    check("t5_no_dup", 32'(dup_seen - d0), 32'd0);

    // clear in FULL discards even with frame_ready
    for (int i = 0; i < 16; i++) begin
      s4 = 4'(i);
      beat(s4, 1'b1);
    end
    check("t5b_full", 32'(frame), 32'hFFFF);
    clear = 1'b1; frame_ready = 1'b1;
    idle(1);
    clear = 1'b0; frame_ready = 1'b0;
    check("t5b_valid", 32'(frame_valid), 32'd0);
    check("t5b_frame", 32'(frame), 32'h0);

`ifdef DEMUX_TIMEOUT_EN
    // 6: idle timeout on a partial frame, and a late beat restarting the count
    d0 = to_seen;
    beat(4'd0, 1'b1); beat(4'd1, 1'b1); beat(4'd2, 1'b1);
    idle(7);
    check("t6_no_early_to", 32'(to_seen - d0), 32'd0);
    idle(1);
    check("t6_to_pulse", 32'(timeout), 32'd1);
    idle(2);
    check("t6_to_once", 32'(to_seen - d0), 32'd1);
    check("t6_fill", 32'(fill_count), 32'd0);
    d0 = to_seen;
    beat(4'd0, 1'b1); beat(4'd1, 1'b1); beat(4'd2, 1'b1);
    idle(6);
    beat(4'd4, 1'b0);
    idle(7);
    check("t6_restart_no_to", 32'(to_seen - d0), 32'd0);
    check("t6_restart_fill", 32'(fill_count), 32'd4);
    do_clear();
`else
    // Without the timeout feature a partial frame waits indefinitely.
    d0 = to_seen;
    beat(4'd0, 1'b1); beat(4'd1, 1'b1); beat(4'd2, 1'b1);
    idle(200);
    check("t6_no_timeout", 32'(to_seen - d0), 32'd0);
    check("t6_fill_kept", 32'(fill_count), 32'd3);
    do_clear();
`endif

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
